// File: rtl/keccak_arbiter_pkg.sv
// Shared definitions for the Keccak permutation arbiter: FSM encoding and state width.
package keccak_arbiter_pkg;

  localparam int KECCAK_BW = 1600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keccak_arbiter_if.sv
// Requester and core-side signals of the Keccak arbiter, bundled for port use.
interface keccak_arbiter_if
  import keccak_arbiter_pkg::*;
#(
  parameter int BW_DATA = KECCAK_BW,
  parameter int N_REQ   = 4
);

  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*BW_DATA-1:0] i_req_state;
  logic [N_REQ-1:0]         o_gnt;
  logic [N_REQ-1:0]         o_rsp_valid;
  logic [BW_DATA-1:0]       o_rsp_state;
  logic [BW_DATA-1:0]       o_core_state;
  logic                     o_core_valid;
  logic [BW_DATA-1:0]       i_core_state;
  logic                     i_core_valid;
  logic                     o_busy;
  logic                     o_err;

  // Arbiter view.
  modport slave (
    input  i_req, i_req_state, i_core_state, i_core_valid,
    output o_gnt, o_rsp_valid, o_rsp_state, o_core_state, o_core_valid,
           o_busy, o_err
  );

  // Requesters plus core: the environment around the arbiter.
  modport master (
    output i_req, i_req_state, i_core_state, i_core_valid,
    input  o_gnt, o_rsp_valid, o_rsp_state, o_core_state, o_core_valid,
           o_busy, o_err
  );

endinterface

// File: rtl/keccak_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping.
module rr_pick
  import keccak_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             vld_o,
  output logic [IW-1:0]    idx_o
);

  int k;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    k     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % N_REQ;
      if (req_i[IW'(k)]) begin
        vld_o = 1'b1;
        idx_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one external keccakf1600 core among N_REQ requesters, round-robin,
// one permutation in flight at a time.
module keccak_arbiter
  import keccak_arbiter_pkg::*;
#(
  parameter int BW_DATA = KECCAK_BW,
  parameter int N_REQ   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  keccak_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [BW_DATA-1:0] core_state_q, core_state_d;
  logic [BW_DATA-1:0] rsp_state_q, rsp_state_d;
  logic               err_q, err_d;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_vld;
  logic               core_vld;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i (bus.i_req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    core_state_d = core_state_q;
    rsp_state_d  = rsp_state_q;
    err_d        = err_q;
    gnt          = '0;
    rsp_vld      = '0;
    core_vld     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          idx_d         = pick_idx;
          gnt[pick_idx] = 1'b1;
          for (int r = 0; r < N_REQ; r++) begin
            if (pick_idx == IW'(r)) core_state_d = bus.i_req_state[r*BW_DATA +: BW_DATA];
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_vld = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_core_valid) begin
          rsp_state_d = bus.i_core_state;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_vld[idx_q] = 1'b1;
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A core result with no operation waiting is a protocol violation.
    if (bus.i_core_valid && state_q != ST_WAIT) err_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ptr_q        <= '0;
      core_state_q <= '0;
      rsp_state_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      core_state_q <= core_state_d;
      rsp_state_q  <= rsp_state_d;
      err_q        <= err_d;
    end
  end

  // Pulses are masked while reset is asserted so nothing leaks out mid-reset.
  assign bus.o_gnt        = i_rst ? '0 : gnt;
  assign bus.o_rsp_valid  = i_rst ? '0 : rsp_vld;
  assign bus.o_core_valid = i_rst ? 1'b0 : core_vld;
  assign bus.o_core_state = core_state_q;
  assign bus.o_rsp_state  = rsp_state_q;
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares; a small core model returns ~state.
module tb_keccak_arbiter;

  localparam int BW = 1600;
  localparam int N  = 4;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [BW-1:0] st;
    int            gap;
  } gnt_t;

  typedef struct {
    logic [N-1:0]  vld;
    logic [BW-1:0] st;
    int            lat;
  } rsp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  gnt_t ge;
  rsp_t re;
  logic [BW-1:0] cur_st = '0;
  int   last_gnt_cyc = 0;
  int   last_rsp_cyc = 0;

  int   core_delay = 24;
  int   cv_at = -1;
  int   spur_at = -1;
  logic [BW-1:0] core_res = '0;

  keccak_arbiter_if #(.BW_DATA(BW), .N_REQ(N)) bus ();

  keccak_arbiter #(.BW_DATA(BW), .N_REQ(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_st(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: low word got %h expected %h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
    end
  endtask

  function automatic logic [BW-1:0] mk_state(input int seed);
    logic [BW-1:0] s;
    for (int k = 0; k < 25; k++) s[k*64 +: 64] = {32'hA5A50000 | 32'(seed), 32'(k * 7 + seed * 131)};
    return s;
  endfunction

  // Core model: answer with ~state core_delay cycles after the start pulse.
  always @(negedge clk) begin
    bus.i_core_valid = 1'b0;
    if (bus.o_core_valid) begin
      core_res = ~bus.o_core_state;
      cv_at    = cyc + core_delay;
    end
    if (cv_at == cyc) begin
      bus.i_core_valid = 1'b1;
      bus.i_core_state = core_res;
      cv_at            = -1;
    end
    if (spur_at == cyc) begin
      bus.i_core_valid = 1'b1;
      bus.i_core_state = mk_state(99);
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.o_gnt != '0) begin
      if (gnt_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL gnt_unexpected: got %b expected none (cycle %0d)", bus.o_gnt, cyc);
      end else begin
        ge = gnt_q.pop_front();
        chk("gnt", 64'(bus.o_gnt), 64'(ge.gnt));
        if (ge.gap >= 0) chk("gnt_gap", 64'(cyc - last_rsp_cyc), 64'(ge.gap));
        cur_st = ge.st;
      end
      last_gnt_cyc = cyc;
    end
    if (bus.o_core_valid) begin
      chk_st("core_state", bus.o_core_state, cur_st);
      chk("core_start_lat", 64'(cyc - last_gnt_cyc), 64'd1);
    end
    if (bus.o_rsp_valid != '0) begin
      if (rsp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got %b expected none (cycle %0d)", bus.o_rsp_valid, cyc);
      end else begin
        re = rsp_q.pop_front();
        chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(re.vld));
        chk_st("rsp_state", bus.o_rsp_state, re.st);
        chk("rsp_lat", 64'(cyc - last_gnt_cyc), 64'(re.lat));
      end
      last_rsp_cyc = cyc;
    end
  end

  task automatic push_op(input int r, input int lat, input int gap, input bit with_rsp);
    logic [BW-1:0] s;
    s = bus.i_req_state[r*BW +: BW];
    gnt_q.push_back('{gnt: N'(1 << r), st: s, gap: gap});
    if (with_rsp) rsp_q.push_back('{vld: N'(1 << r), st: ~s, lat: lat});
  endtask

  // Raise mask; after each of n grants optionally drop the granted bit.
  task automatic serve(input logic [N-1:0] mask, input int n, input bit drop);
    logic [N-1:0] g;
    bit got;
    @(posedge clk); #1;
    bus.i_req = mask;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      g   = '0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (bus.o_gnt != '0) begin
          g   = bus.o_gnt;
          got = 1'b1;
        end
      end
      if (!got) begin
        n_chk++; n_fail++;
        $display("FAIL gnt_timeout: got none expected grant %0d of %0d", k + 1, n);
      end
      @(posedge clk); #1;
      if (drop) bus.i_req = bus.i_req & ~g;
    end
    if (!drop) bus.i_req = '0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge clk);
      idle = !bus.o_busy;
    end
    if (!idle) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.i_req = '0;
    for (int r = 0; r < N; r++) bus.i_req_state[r*BW +: BW] = mk_state(r + 1);
    bus.i_core_state = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(bus.o_gnt), 64'd0);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_core_valid", 64'(bus.o_core_valid), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
    chk_st("rst_core_state", bus.o_core_state, '0);
    chk_st("rst_rsp_state", bus.o_rsp_state, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request, 24-cycle core: rsp 26 cycles after grant.
    core_delay = 24;
    push_op(0, 26, -1, 1'b1);
    serve(4'b0001, 1, 1'b1);
    wait_idle();
    chk_st("core_state_hold", bus.o_core_state, mk_state(1));
    chk_st("rsp_state_hold", bus.o_rsp_state, ~mk_state(1));

    // All requesters held: strict rotation from pointer 0.
    do_reset();
    core_delay = 2;
    for (int k = 0; k < 8; k++) push_op(k % N, 4, -1, 1'b1);
    serve(4'b1111, 8, 1'b0);
    wait_idle();

    // Pointer moved to 2 by a grant to 1, then 1010 -> 3 before 1.
    core_delay = 5;
    push_op(1, 7, -1, 1'b1);
    serve(4'b0010, 1, 1'b1);
    wait_idle();
    push_op(3, 7, -1, 1'b1);
    push_op(1, 7, -1, 1'b1);
    serve(4'b1010, 2, 1'b1);
    wait_idle();

    // One-cycle core: rsp 3 cycles after grant, next grant on the next IDLE cycle.
    core_delay = 1;
    push_op(2, 3, -1, 1'b1);
    push_op(0, 3, 1, 1'b1);
    serve(4'b0101, 2, 1'b1);
    wait_idle();

    // Stray core result while idle: sticky error, no response.
    chk("err_before_spur", 64'(bus.o_err), 64'd0);
    @(posedge clk); #1 spur_at = cyc + 2;
    repeat (5) @(negedge clk);
    chk("err_after_spur", 64'(bus.o_err), 64'd1);
    chk("busy_after_spur", 64'(bus.o_busy), 64'd0);
    repeat (10) @(negedge clk);
    chk("err_sticky", 64'(bus.o_err), 64'd1);
    chk("rsp_valid_quiet", 64'(bus.o_rsp_valid), 64'd0);

    // Reset while waiting on the core; the late result flags an error.
    do_reset();
    chk("err_cleared", 64'(bus.o_err), 64'd0);
    core_delay = 20;
    push_op(2, 0, -1, 1'b0);
    serve(4'b0100, 1, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_in_wait", 64'(bus.o_busy), 64'd1);
    do_reset();
    @(negedge clk);
    chk("busy_after_abort", 64'(bus.o_busy), 64'd0);
    chk("err_after_abort", 64'(bus.o_err), 64'd0);
    repeat (30) @(negedge clk);
    chk("err_stale_result", 64'(bus.o_err), 64'd1);
    core_delay = 3;
    push_op(0, 5, -1, 1'b1);
    serve(4'b1001, 1, 1'b1);
    @(posedge clk); #1 bus.i_req = '0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
